// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped GPIO with atomic set/clear/toggle, synchronised inputs and edge IRQ
// Ports: CLK rising-edge clock; RSTN async active-low reset; MADDR/MDATAO/MWSTB/WE/RE bus request;
// RDATA/HIT registered read response; GPIO_IN async inputs; GPIO_OUT outputs; IRQ level interrupt.
// Build option: define GPIO_IRQ_EN to include edge detect, IRQ_EN/IRQ_STAT/IRQ_EDGE and IRQ.
module mmio_gpio #(
    parameter logic [31:0] GPIO_BASE  = 32'h0012_0000,
    parameter int          GPIO_WIDTH = 32,
    parameter logic [31:0] OUT_RESET  = 32'h0
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [31:2]           MADDR,
    input  logic [31:0]           MDATAO,
    input  logic [3:0]            MWSTB,
    input  logic                  WE,
    input  logic                  RE,
    output logic [31:0]           RDATA,
    output logic                  HIT,
    input  logic [GPIO_WIDTH-1:0] GPIO_IN,
    output logic [GPIO_WIDTH-1:0] GPIO_OUT,
    output logic                  IRQ
);
    localparam logic [31:0] W_MASK = GPIO_WIDTH >= 32 ? 32'hFFFF_FFFF : (32'h1 << GPIO_WIDTH) - 32'h1;
    logic [GPIO_WIDTH-1:0] r_sync1, r_sync2;
    logic [31:0]           r_out, r_rdata;
    logic                  r_hit;
    logic [31:0]           w_lane, w_set, w_in, w_out_nxt, w_rdata;
    logic                  w_sel, w_wr, w_rd;
    logic [2:0]            w_idx;
    assign w_sel = (WE | RE) && MADDR[31:5] == GPIO_BASE[31:5];
    assign w_wr  = WE & w_sel;
    assign w_rd  = RE & w_sel;
    assign w_idx = MADDR[4:2];
    // Byte-lane mask limited to implemented channels; all write kinds are gated by it.
    assign w_lane = {{8{MWSTB[3]}}, {8{MWSTB[2]}}, {8{MWSTB[1]}}, {8{MWSTB[0]}}} & W_MASK;
    assign w_set  = MDATAO & w_lane;
    assign w_in   = 32'(r_sync2);
    assign w_out_nxt = !w_wr          ? r_out :
                       w_idx == 3'd0  ? (r_out & ~w_lane) | w_set :
                       w_idx == 3'd1  ? r_out | w_set :
                       w_idx == 3'd2  ? r_out & ~w_set :
                       w_idx == 3'd3  ? r_out ^ w_set : r_out;
`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] r_prev;
    logic [31:0]           r_en, r_stat, r_edge, w_ev, w_w1c;
    assign w_ev  = (r_edge & w_in & ~32'(r_prev)) | (~r_edge & ~w_in & 32'(r_prev));
    assign w_w1c = (w_wr && w_idx == 3'd6) ? w_set : 32'h0;
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_prev <= '0;
            r_en   <= '0;
            r_stat <= '0;
            r_edge <= '0;
        end else begin
            r_prev <= r_sync2;
            r_en   <= (w_wr && w_idx == 3'd5) ? (r_en & ~w_lane) | w_set : r_en;
            r_edge <= (w_wr && w_idx == 3'd7) ? (r_edge & ~w_lane) | w_set : r_edge;
            // Event OR-ed in after the clear so a same-cycle event survives the W1C.
            r_stat <= (r_stat & ~w_w1c) | w_ev;
        end
    end
    assign IRQ = |(r_stat & r_en);
    assign w_rdata = w_idx == 3'd0 ? r_out :
                     w_idx == 3'd4 ? w_in :
                     w_idx == 3'd5 ? r_en :
                     w_idx == 3'd6 ? r_stat :
                     w_idx == 3'd7 ? r_edge : 32'h0;
`else
    assign IRQ = 1'b0;
    assign w_rdata = w_idx == 3'd0 ? r_out :
                     w_idx == 3'd4 ? w_in : 32'h0;
`endif
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_out   <= OUT_RESET & W_MASK;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_rdata <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_out   <= w_out_nxt;
            r_sync1 <= GPIO_IN;
            r_sync2 <= r_sync1;
            r_hit   <= w_rd;
            if (w_rd)
                r_rdata <= w_rdata;
        end
    end
    assign GPIO_OUT = r_out[GPIO_WIDTH-1:0];
    assign RDATA    = r_rdata;
    assign HIT      = r_hit;
endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio: self-checking bench for mmio_gpio (32-channel instance plus an 8-channel instance)
`timescale 1ns/1ps
module tb_mmio_gpio;
    localparam logic [31:0] BASE  = 32'h0012_0000;
    localparam logic [31:0] BASE2 = 32'h0013_0000;
`ifdef GPIO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:2] maddr;
    logic [31:0] mdatao;
    logic [3:0]  mwstb;
    logic        we, re;
    logic [31:0] rdata, rdata2, gin, gout;
    logic        hit, hit2, irq, irq2;
    logic [7:0]  gin8, gout8;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mmio_gpio #(.GPIO_BASE(BASE), .GPIO_WIDTH(32), .OUT_RESET(32'h0)) dut (
        .CLK(clk), .RSTN(rstn), .MADDR(maddr), .MDATAO(mdatao), .MWSTB(mwstb), .WE(we), .RE(re),
        .RDATA(rdata), .HIT(hit), .GPIO_IN(gin), .GPIO_OUT(gout), .IRQ(irq));
    mmio_gpio #(.GPIO_BASE(BASE2), .GPIO_WIDTH(8), .OUT_RESET(32'hA5)) dut8 (
        .CLK(clk), .RSTN(rstn), .MADDR(maddr), .MDATAO(mdatao), .MWSTB(mwstb), .WE(we), .RE(re),
        .RDATA(rdata2), .HIT(hit2), .GPIO_IN(gin8), .GPIO_OUT(gout8), .IRQ(irq2));

    // Reference model of the 32-channel instance: register file plus history of sampled inputs
    // (hist[0] = newest edge sample). IN is the sample two edges old, prev is three edges old.
    logic [31:0] m_out, m_en, m_stat, m_edge, m_rdata;
    logic        m_hit;
    logic [31:0] hist [3];

    task automatic m_reset;
        m_out = 0; m_en = 0; m_stat = 0; m_edge = 0; m_rdata = 0; m_hit = 0;
        for (int i = 0; i < 3; i++) hist[i] = 0;
    endtask

    task automatic m_step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] g);
        logic [31:0] bm, dm, rd;
        logic sel;
        int idx;
        for (int i = 0; i < 4; i++) bm[i*8 +: 8] = {8{s[i]}};
        sel = (w | r) && a[31:5] == BASE[31:5];
        idx = int'(a[4:2]);
        dm  = d & bm;
        rd  = 0;
        if (idx == 0) rd = m_out;
        if (idx == 4) rd = hist[1];
`ifdef GPIO_IRQ_EN
        if (idx == 5) rd = m_en;
        if (idx == 6) rd = m_stat;
        if (idx == 7) rd = m_edge;
`endif
        m_hit = r && sel;
        if (m_hit) m_rdata = rd;
`ifdef GPIO_IRQ_EN
        begin
            logic [31:0] ev;
            for (int i = 0; i < 32; i++)
                ev[i] = m_edge[i] ? (hist[1][i] && !hist[2][i]) : (!hist[1][i] && hist[2][i]);
            if (w && sel && idx == 6) m_stat = m_stat & ~dm;
            m_stat = m_stat | ev;
        end
`endif
        if (w && sel) begin
            case (idx)
                0: m_out = (m_out & ~bm) | dm;
                1: m_out = m_out | dm;
                2: m_out = m_out & ~dm;
                3: m_out = m_out ^ dm;
`ifdef GPIO_IRQ_EN
                5: m_en = (m_en & ~bm) | dm;
                7: m_edge = (m_edge & ~bm) | dm;
`endif
                default: ;
            endcase
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = g;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // One bus cycle: drive, let the edge happen, step the model, compare 1ns after the edge.
    task automatic cycle(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        we = w; re = r; maddr = a[31:2]; mdatao = d; mwstb = s;
        @(posedge clk);
        m_step(w, r, a, d, s, gin);
        #1;
        chk("gpio_out", gout, m_out);
        chk("hit", 32'(hit), 32'(m_hit));
        chk("rdata", rdata, m_rdata);
        chk("irq", 32'(irq), IRQ_ON ? 32'(|(m_stat & m_en)) : 32'h0);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    typedef struct {
        logic w; logic r; logic [31:0] a; logic [31:0] d; logic [3:0] s;
        logic [31:0] eout; logic ehit; logic [31:0] erd;
    } vec_t;
    vec_t vec [13];

    int k, o;
    logic [31:0] ra;

    initial begin
        vec[0]  = '{1'b1, 1'b0, BASE,            32'h1234_5678, 4'b0010, 32'h0000_5600, 1'b0, 32'h0};
        vec[1]  = '{1'b1, 1'b0, BASE + 32'h4,    32'h0000_00FF, 4'hF,    32'h0000_56FF, 1'b0, 32'h0};
        vec[2]  = '{1'b1, 1'b0, BASE + 32'h8,    32'h0000_000F, 4'hF,    32'h0000_56F0, 1'b0, 32'h0};
        vec[3]  = '{1'b1, 1'b0, BASE + 32'hC,    32'hFFFF_FFFF, 4'hF,    32'hFFFF_A90F, 1'b0, 32'h0};
        vec[4]  = '{1'b0, 1'b1, BASE + 32'h4,    32'h0,         4'h0,    32'hFFFF_A90F, 1'b1, 32'h0};
        vec[5]  = '{1'b0, 1'b1, BASE + 32'h8,    32'h0,         4'h0,    32'hFFFF_A90F, 1'b1, 32'h0};
        vec[6]  = '{1'b0, 1'b1, BASE + 32'hC,    32'h0,         4'h0,    32'hFFFF_A90F, 1'b1, 32'h0};
        vec[7]  = '{1'b0, 1'b1, BASE,            32'h0,         4'h0,    32'hFFFF_A90F, 1'b1, 32'hFFFF_A90F};
        vec[8]  = '{1'b0, 1'b1, BASE + 32'h20,   32'h0,         4'h0,    32'hFFFF_A90F, 1'b0, 32'hFFFF_A90F};
        vec[9]  = '{1'b1, 1'b0, BASE + 32'h20,   32'h0,         4'hF,    32'hFFFF_A90F, 1'b0, 32'hFFFF_A90F};
        vec[10] = '{1'b1, 1'b0, 32'h0000_1000,   32'h0,         4'hF,    32'hFFFF_A90F, 1'b0, 32'hFFFF_A90F};
        vec[11] = '{1'b0, 1'b1, 32'h0000_1000,   32'h0,         4'h0,    32'hFFFF_A90F, 1'b0, 32'hFFFF_A90F};
        vec[12] = '{1'b1, 1'b1, BASE,            32'h0,         4'h1,    32'hFFFF_A900, 1'b1, 32'hFFFF_A90F};

        we = 0; re = 0; maddr = '0; mdatao = '0; mwstb = '0; gin = '0; gin8 = '0;
        m_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        chk("reset_out", gout, 32'h0);
        chk("reset_out8", 32'(gout8), 32'hA5);
        chk("reset_hit", 32'(hit), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);

        // 8-channel instance: reset value, width masking, input path
        cycle(1'b0, 1'b1, BASE2, 32'h0, 4'h0);
        chk("w8_hit", 32'(hit2), 32'h1);
        chk("w8_rd_reset", rdata2, 32'h0000_00A5);
        cycle(1'b1, 1'b0, BASE2, 32'hFFFF_FFFF, 4'hF);
        chk("w8_out_ff", 32'(gout8), 32'hFF);
        cycle(1'b0, 1'b1, BASE2, 32'h0, 4'h0);
        chk("w8_rd_masked", rdata2, 32'h0000_00FF);
        gin8 = 8'h5A;
        idle(2);
        cycle(1'b0, 1'b1, BASE2 + 32'h10, 32'h0, 4'h0);
        chk("w8_in", rdata2, 32'h0000_005A);
        cycle(1'b1, 1'b0, BASE2 + 32'h8, 32'hFFFF_FFFF, 4'hF);
        chk("w8_clr", 32'(gout8), 32'h0);

        for (int i = 0; i < 13; i++) begin
            cycle(vec[i].w, vec[i].r, vec[i].a, vec[i].d, vec[i].s);
            chk($sformatf("vec%0d_out", i), gout, vec[i].eout);
            chk($sformatf("vec%0d_hit", i), 32'(hit), 32'(vec[i].ehit));
            chk($sformatf("vec%0d_rdata", i), rdata, vec[i].erd);
        end

        // Rising edge on bit 3 raises IRQ two edges after the input change
        cycle(1'b1, 1'b0, BASE + 32'h1C, 32'h8, 4'hF);
        cycle(1'b1, 1'b0, BASE + 32'h14, 32'h8, 4'hF);
        gin = 32'h8;
        idle(2);
        chk("irq_edge1", 32'(irq), 32'h0);
        idle(1);
        chk("irq_edge2", 32'(irq), 32'(IRQ_ON));
        cycle(1'b0, 1'b1, BASE + 32'h18, 32'h0, 4'h0);
        chk("stat_rd", rdata, IRQ_ON ? 32'h8 : 32'h0);
        cycle(1'b1, 1'b0, BASE + 32'h18, 32'h8, 4'hF);
        chk("irq_w1c", 32'(irq), 32'h0);

        // Falling event on bit 0 coincides with W1C of bit 0: set wins
        gin = 32'h9;
        idle(3);
        gin = 32'h8;
        idle(2);
        cycle(1'b1, 1'b0, BASE + 32'h18, 32'h1, 4'hF);
        cycle(1'b0, 1'b1, BASE + 32'h18, 32'h0, 4'h0);
        chk("stat_set_wins", rdata, IRQ_ON ? 32'h1 : 32'h0);
        cycle(1'b1, 1'b0, BASE + 32'h18, 32'h1, 4'hF);
        cycle(1'b0, 1'b1, BASE + 32'h18, 32'h0, 4'h0);
        chk("stat_cleared", rdata, 32'h0);

        // Asynchronous reset between edges with IRQ high and outputs nonzero
        cycle(1'b1, 1'b0, BASE + 32'h14, 32'h9, 4'hF);
        gin = 32'h9;
        idle(3);
        gin = 32'h8;
        idle(3);
        chk("irq_pre_reset", 32'(irq), 32'(IRQ_ON));
        cycle(1'b1, 1'b0, BASE2, 32'h0000_00FF, 4'hF);
        cycle(1'b0, 1'b1, BASE, 32'h0, 4'h0);
        chk("hit_pre_reset", 32'(hit), 32'h1);
        #2 rstn = 1'b0;
        #1;
        chk("areset_out", gout, 32'h0);
        chk("areset_out8", 32'(gout8), 32'hA5);
        chk("areset_irq", 32'(irq), 32'h0);
        chk("areset_hit", 32'(hit), 32'h0);
        chk("areset_rdata", rdata, 32'h0);
        chk("areset_rdata8", rdata2, 32'h0);
        m_reset();
        @(negedge clk);
        rstn = 1'b1;

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            o = $urandom_range(0, 9);
            ra = o < 8 ? BASE + 32'(o * 4) : (o == 8 ? BASE + 32'h20 : 32'h0000_1000);
            if (n % 2 == 0) gin = $urandom;
            cycle(k < 4 || k == 8, (k >= 4 && k < 8) || k == 8, ra, $urandom, 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mmio_gpio.md
# mmio_gpio

Parametrised memory-mapped GPIO peripheral for the RV32I data bus; successor to the single fixed LED output register. It sits beside `dmem` on the word-addressed, byte-strobed bus driven by the data aligner. It provides up to 32 output channels with atomic set/clear/toggle, synchronised inputs, and sticky edge-detect interrupt status. The top-level read multiplexer selects `RDATA` when `HIT` is high.

## Interface
- `GPIO_BASE`, default `32'h0012_0000`: byte base address; must be 32-byte aligned.
- `GPIO_WIDTH`, default 32: channel count, 1..32. Bits at and above `GPIO_WIDTH` read 0 and ignore writes.
- `OUT_RESET`, default `32'h0`: reset value of the output register.
- `CLK`, input, 1: clock, rising edge.
- `RSTN`, input, 1: one clock; reset is asynchronous and active-low.
- `MADDR`, input, [31:2]: word address.
- `MDATAO`, input, 32: write data, already lane-positioned.
- `MWSTB`, input, 4: byte write strobes.
- `WE`, input, 1: write cycle (`|MemWrite`).
- `RE`, input, 1: read cycle (`|MemRead`).
- `RDATA`, output, 32: registered read data.
- `HIT`, output, 1: registered; high when `RDATA` belongs to this block.
- `GPIO_IN`, input, `GPIO_WIDTH`: asynchronous external inputs.
- `GPIO_OUT`, output, `GPIO_WIDTH`: driven outputs.
- `IRQ`, output, 1: level interrupt.

## Operation
- Select: `sel = (WE|RE) && MADDR[31:5] == GPIO_BASE[31:5]`. Register index is `MADDR[4:2]`.
- Register map (byte offset):
  - 0x00 OUT: RW; each byte updates only where its `MWSTB` bit is set.
  - 0x04 OUT_SET: write-1-to-set; reads 0.
  - 0x08 OUT_CLR: write-1-to-clear; reads 0.
  - 0x0C OUT_TGL: write-1-to-toggle; reads 0.
  - 0x10 IN: RO; returns synchronised inputs (`sync2`). Writes ignored.
  - 0x14 IRQ_EN: RW, reset 0.
  - 0x18 IRQ_STAT: sticky; write-1-to-clear; reset 0.
  - 0x1C IRQ_EDGE: RW, reset 0. 1 = rising edge, 0 = falling edge, per bit.
- SET/CLR/TGL masks are gated by `MWSTB` byte lanes. Masked-off bytes are unaffected.
- Input path: 3-flop chain `sync1 -> sync2 -> prev`, all reset to 0.
  - rise = `sync2 & ~prev`; fall = `~sync2 & prev`.
  - ev = `IRQ_EDGE ? rise : fall`, per bit.
- Status update: `STAT <= (STAT & ~w1c) | ev`. If an event and a W1C on the same bit occur in the same cycle, the set wins.
- `IRQ = |(STAT & IRQ_EN)`, combinational from flops only (glitch-free).
- `RE` and `WE` are never asserted together (bus rule). If both are asserted, the write executes and `RDATA` returns the pre-write value.
- Reset (async, any time, including mid-access): `GPIO_OUT = OUT_RESET`; `RDATA`, `HIT`, `IRQ_EN`, `IRQ_STAT`, `IRQ_EDGE`, and the sync chain go to 0; `IRQ = 0`.

## Timing
- Write: takes effect at the rising edge where `WE & sel`. `GPIO_OUT` changes immediately after that edge.
- Read: `RDATA` and `HIT` are registered at the edge where `RE & sel`, giving 1-cycle latency (matches `dmem`).
  - Value returned is the register content before that edge.
  - `HIT` is low after any edge where `RE & sel` is false. `RDATA` holds its last value.
- Input: a `GPIO_IN` change set up before edge 0 is visible in IN after edge 1. STAT sets at edge 2, and `IRQ` rises after edge 2 if enabled.
- An input held high through reset produces a rising event at edge 2 after reset release.
- Pulses shorter than one clock may be missed; this is not a requirement.

## Configuration
- `GPIO_IRQ_EN` defined: edge detect, `prev` flops, IRQ_EN/IRQ_STAT/IRQ_EDGE registers, and `IRQ` are present as described above.
- Not defined:
  - Offsets 0x14–0x1C read 0 and ignore writes.
  - `IRQ` is tied to 0.
  - The sync chain is 2 flops only.
  - All other behaviour is identical.

## Test plan
- Reset with `OUT_RESET = 32'hA5`, `GPIO_WIDTH = 8` -> `GPIO_OUT = 8'hA5`. A read of 0x00 returns `32'h0000_00A5` one cycle later with `HIT = 1`.
- Write 0x00 `32'h1234_5678` with `MWSTB = 4'b0010` (`GPIO_WIDTH = 32`, OUT = 0) -> OUT = `32'h0000_5600`. Then SET `32'hFF` (`MWSTB = 4'hF`) -> `32'h0000_56FF`. Then CLR `32'h0F` -> `32'h0000_56F0`. Then TGL `32'hFFFF_FFFF` -> `32'hFFFF_A90F`.
- Access to `GPIO_BASE + 32'h20` and to `dmem` space -> `HIT` stays 0 and no register changes. Reads of SET/CLR/TGL return 0.
- `IRQ_EDGE[3] = 1`, `IRQ_EN[3] = 1`; raise `GPIO_IN[3]` before edge 0 -> `IRQ_STAT = 32'h8` after edge 2 and `IRQ = 1`. W1C `32'h8` -> `IRQ = 0` after that edge.
- Falling-edge event on bit 0 in the same cycle as a W1C of bit 0 -> bit 0 remains set. A W1C the next cycle clears it.
- Assert `RSTN` low mid-sequence, asynchronously between edges, with `IRQ = 1` and OUT nonzero -> `IRQ`, `HIT`, `RDATA` go to 0 and `GPIO_OUT = OUT_RESET` immediately, without a clock edge. With `GPIO_IRQ_EN` undefined, the edge scenario gives `IRQ = 0` and 0x18 reads 0.
